gam_connection_scheduler: RTL and testbench
===========================================

# gam_connection_scheduler

Sequencing controller for the GAM memory layer's per-class connection memory. It accepts connection-update requests from the learning datapath and executes the edge set plus the neighbour-age sweep as read-modify-write cycles on a single-port connection memory. On end of learning it runs the prune sweep: it clears every connection whose age has reached AGE_MAX and emits invalidate strobes for nodes left with no connections. It arbitrates the memory between these two activities.

## Interface
- NODE_COUNT, 8, node index range; index 0 is reserved/unused, valid nodes are 1..NODE_COUNT-1
- CLASS_COUNT, 4, class index range; valid classes are 1..CLASS_COUNT-1
- AGE_MAX, 10, prune threshold; an edge with age >= AGE_MAX is removed
- AGE_W, 8, age field width
- NW, $clog2(NODE_COUNT), node index width; CW, $clog2(CLASS_COUNT), class index width
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- upd_valid  in  1  update request valid
- upd_ready  out  1  update accepted when valid&ready
- upd_node1, upd_node2  in  NW  edge endpoints (winner, second winner); node2=0 means none
- upd_class  in  CW  class of the edge
- upd_drop  out  1  one-cycle pulse: accepted request discarded
- prune_start  in  1  learning-done pulse
- prune_done  out  1  one-cycle pulse at prune completion
- busy  out  1  high in any non-IDLE state
- mem_en, mem_we  out  1  memory access strobe / write enable
- mem_class  out  CW; mem_row, mem_col  out  NW  entry address
- mem_wpres  out  1; mem_wage  out  AGE_W  write data
- mem_rpres  in  1; mem_rage  in  AGE_W  read data, valid the cycle after a read (mem_en & !mem_we)
- inv_we  out  1; inv_class  out  CW; inv_node  out  NW  invalidate-node strobe and address

## Operation
- States: IDLE, SET_FWD, SET_REV, AGE_RD, AGE_WR1, AGE_WR2, PR_RD, PR_EVAL, PR_DONE.
- IDLE: upd_ready=1. A request is dropped (upd_drop=1, no memory access, remain IDLE) if node1 or node2 is 0, node1==node2, or any index is out of range. Otherwise go to SET_FWD.
- SET_FWD: write [c][n1][n2] with pres=1, age=0. SET_REV: write [c][n2][n1] with pres=1, age=0.
- Age sweep: i steps over 1..NODE_COUNT-1, skipping n1 and n2 (skipped indices cost 0 cycles).
  - AGE_RD: read [c][n1][i].
  - AGE_WR1: if rpres, write [c][n1][i] with pres=1, age=sat(rage+1).
  - AGE_WR2: if rpres, write [c][i][n1] with the same value.
  - Increments are conditional on presence, in both directions, which keeps the matrix symmetric.
  - sat() clamps at 2^AGE_W-1.
  - After the last i, return to IDLE.
- Prune: loops c=1..CLASS_COUNT-1, i=1..NODE_COUNT-1, j=1..NODE_COUNT-1.
  - PR_RD: read [c][i][j].
  - PR_EVAL: if rpres && rage>=AGE_MAX, write pres=0 (age unchanged). If rpres && rage<AGE_MAX, set the row's survivor flag.
  - At the PR_EVAL for j=NODE_COUNT-1, if the survivor flag is 0, pulse inv_we with (c,i) in that same cycle. The flag clears at each row start.
  - After the final entry go to PR_DONE: prune_done=1 for one cycle, then IDLE.
- Arbitration:
  - prune_start and upd_valid in the same IDLE cycle: prune wins and the request is not accepted.
  - prune_start during an update is latched as pending. Prune begins the cycle after the update returns to IDLE, and upd_ready stays 0 on that cycle.
  - prune_start during prune is ignored.
  - No update is accepted during prune.
- This block never writes the invalid-node list directly. It only issues inv_* strobes.

## Timing
- Reset: all outputs 0, except that upd_ready=1 from the first cycle after rst deasserts. State goes to IDLE and the pending prune clears.
- Reset mid-operation abandons the sequence: no further mem_en, no prune_done. Memory contents are left as-is.
- Update latency after the accept cycle: 2 + 3*(NODE_COUNT-3) cycles, which is 17 for NODE_COUNT=8. upd_ready returns the cycle after.
- Prune length: 2*(CLASS_COUNT-1)*(NODE_COUNT-1)^2 cycles, which is 294 with defaults. prune_done follows in the next cycle.
- At most one memory access per cycle. mem_rdata is sampled only in AGE_WR1/PR_EVAL.
- upd_drop is asserted in the accept cycle.

## Test plan
- Zeroed memory, update (1,2,class 1): writes [1][1][2] then [1][2][1] with pres=1, age 0. No other writes. upd_ready is high again 18 cycles after the accept.
- Preload [1][1][3]/[1][3][1] pres=1 age=4, and [1][1][5]/[1][5][1] age=255. Update (1,2,1): [1][3] and [3][1] become age 5. [1][5] and [5][1] are written at 255 (saturation). Absent entries are never written.
- upd_node2=0, and separately node1==node2: upd_drop pulses for one cycle, no mem_en, upd_ready stays 1.
- Class 1 with [2][4]/[4][2] age 10 and [1][2]/[2][1] age 3, all else empty. Prune: pres clears at [1][2][4] and [1][4][2]. inv_we fires for class 1 nodes 3,4,5,6,7 and for all nodes of classes 2 and 3, but not for class 1 nodes 1,2. prune_done comes 295 cycles after start.
- prune_start asserted 5 cycles into an update: the update completes all writes, PR_RD starts the next cycle, and upd_valid held high is not accepted until after prune_done.
- rst asserted at cycle 100 of a prune: the next cycle has all outputs 0 and upd_ready=1 after release. No prune_done and no inv_we is ever emitted.

Source files
------------

// File: rtl/gam_connection_scheduler.sv
// Connection-memory sequencer for one GAM layer: runs edge-set plus neighbour-age
// read-modify-write updates, and the end-of-learning prune sweep with node invalidation.
module gam_connection_scheduler #(
    parameter int  NODE_COUNT  = 8,
    parameter int  CLASS_COUNT = 4,
    parameter int  AGE_MAX     = 10,
    parameter int  AGE_W       = 8,
    localparam int NW          = $clog2(NODE_COUNT),
    localparam int CW          = $clog2(CLASS_COUNT)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_upd_valid,
    output logic             o_upd_ready,
    input  logic [NW-1:0]    i_upd_node1,
    input  logic [NW-1:0]    i_upd_node2,
    input  logic [CW-1:0]    i_upd_class,
    output logic             o_upd_drop,
    input  logic             i_prune_start,
    output logic             o_prune_done,
    output logic             o_busy,
    output logic             o_mem_en,
    output logic             o_mem_we,
    output logic [CW-1:0]    o_mem_class,
    output logic [NW-1:0]    o_mem_row,
    output logic [NW-1:0]    o_mem_col,
    output logic             o_mem_wpres,
    output logic [AGE_W-1:0] o_mem_wage,
    input  logic             i_mem_rpres,
    input  logic [AGE_W-1:0] i_mem_rage,
    output logic             o_inv_we,
    output logic [CW-1:0]    o_inv_class,
    output logic [NW-1:0]    o_inv_node
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_SET_FWD = 4'd1,
        S_SET_REV = 4'd2,
        S_AGE_RD  = 4'd3,
        S_AGE_WR1 = 4'd4,
        S_AGE_WR2 = 4'd5,
        S_PR_RD   = 4'd6,
        S_PR_EVAL = 4'd7,
        S_PR_DONE = 4'd8
    } state_t;

    function automatic logic node_ok(input logic [NW-1:0] n);
        return (n != {NW{1'b0}}) && (int'(n) < NODE_COUNT);
    endfunction

    function automatic logic class_ok(input logic [CW-1:0] c);
        return (c != {CW{1'b0}}) && (int'(c) < CLASS_COUNT);
    endfunction

    // First sweep index >= start that is neither endpoint; NODE_COUNT when exhausted.
    function automatic logic [NW:0] next_idx(input logic [NW:0] start,
                                              input logic [NW-1:0] a,
                                              input logic [NW-1:0] b);
        logic [NW:0] res;
        logic        found;
        res   = (NW+1)'(NODE_COUNT);
        found = 1'b0;
        for (int k = 1; k < NODE_COUNT; k++) begin
            if (!found && (k >= int'(start)) && (k != int'(a)) && (k != int'(b))) begin
                res   = (NW+1)'(k);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
        return (a == {AGE_W{1'b1}}) ? a : a + {{(AGE_W-1){1'b0}}, 1'b1};
    endfunction

    state_t            r_state, w_nxt;
    logic              r_pend, r_surv, r_apres;
    logic [NW-1:0]     r_n1, r_n2, r_i, r_pi, r_pj;
    logic [CW-1:0]     r_c, r_pc;
    logic [AGE_W-1:0]  r_awage;

    logic              w_ready, w_drop, w_done, w_en, w_we, w_wpres, w_inv_we;
    logic [CW-1:0]     w_class, w_inv_class;
    logic [NW-1:0]     w_row, w_col, w_inv_node;
    logic [AGE_W-1:0]  w_wage;

    logic          w_req_ok, w_upd_state, w_last_j, w_last_i, w_last_c;
    logic          w_expire, w_surv;
    logic [NW:0]   w_first, w_next;

    assign w_req_ok    = node_ok(i_upd_node1) && node_ok(i_upd_node2) &&
                         (i_upd_node1 != i_upd_node2) && class_ok(i_upd_class);
    assign w_upd_state = (r_state == S_SET_FWD) || (r_state == S_SET_REV) || (r_state == S_AGE_RD) ||
                         (r_state == S_AGE_WR1) || (r_state == S_AGE_WR2);
    assign w_first     = next_idx((NW+1)'(1), r_n1, r_n2);
    assign w_next      = next_idx({1'b0, r_i} + (NW+1)'(1), r_n1, r_n2);
    assign w_last_j    = (r_pj == NW'(NODE_COUNT-1));
    assign w_last_i    = (r_pi == NW'(NODE_COUNT-1));
    assign w_last_c    = (r_pc == CW'(CLASS_COUNT-1));
    assign w_expire    = i_mem_rpres && (i_mem_rage >= AGE_W'(AGE_MAX));
    assign w_surv      = r_surv || (i_mem_rpres && !w_expire);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    // Next-state and per-state memory/strobe decode.
    always_comb begin
        w_nxt       = r_state;
        w_ready     = 1'b0;
        w_drop      = 1'b0;
        w_done      = 1'b0;
        w_en        = 1'b0;
        w_we        = 1'b0;
        w_wpres     = 1'b0;
        w_wage      = {AGE_W{1'b0}};
        w_class     = {CW{1'b0}};
        w_row       = {NW{1'b0}};
        w_col       = {NW{1'b0}};
        w_inv_we    = 1'b0;
        w_inv_class = {CW{1'b0}};
        w_inv_node  = {NW{1'b0}};
        case (r_state)
            S_IDLE: begin
                w_ready = !r_pend && !i_prune_start;
                if (r_pend || i_prune_start) begin
                    w_nxt = S_PR_RD;
                end else if (i_upd_valid) begin
                    if (w_req_ok) begin
                        w_nxt = S_SET_FWD;
                    end else begin
                        w_drop = 1'b1;
                    end
                end else begin
                    w_nxt = S_IDLE;
                end
            end
            S_SET_FWD: begin
                {w_en, w_we, w_wpres} = 3'b111;
                {w_class, w_row, w_col} = {r_c, r_n1, r_n2};
                w_nxt = S_SET_REV;
            end
            S_SET_REV: begin
                {w_en, w_we, w_wpres} = 3'b111;
                {w_class, w_row, w_col} = {r_c, r_n2, r_n1};
                w_nxt = (w_first == (NW+1)'(NODE_COUNT)) ? S_IDLE : S_AGE_RD;
            end
            S_AGE_RD: begin
                w_en = 1'b1;
                {w_class, w_row, w_col} = {r_c, r_n1, r_i};
                w_nxt = S_AGE_WR1;
            end
            S_AGE_WR1: begin
                {w_en, w_we, w_wpres} = {i_mem_rpres, i_mem_rpres, 1'b1};
                {w_class, w_row, w_col} = {r_c, r_n1, r_i};
                w_wage = sat_inc(i_mem_rage);
                w_nxt = S_AGE_WR2;
            end
            S_AGE_WR2: begin
                {w_en, w_we, w_wpres} = {r_apres, r_apres, 1'b1};
                {w_class, w_row, w_col} = {r_c, r_i, r_n1};
                w_wage = r_awage;
                w_nxt = (w_next == (NW+1)'(NODE_COUNT)) ? S_IDLE : S_AGE_RD;
            end
            S_PR_RD: begin
                w_en = 1'b1;
                {w_class, w_row, w_col} = {r_pc, r_pi, r_pj};
                w_nxt = S_PR_EVAL;
            end
            S_PR_EVAL: begin
                // Expired edges keep their age; only the presence bit drops.
                {w_en, w_we, w_wpres} = {w_expire, w_expire, 1'b0};
                {w_class, w_row, w_col} = {r_pc, r_pi, r_pj};
                w_wage      = i_mem_rage;
                w_inv_we    = w_last_j && !w_surv;
                w_inv_class = r_pc;
                w_inv_node  = r_pi;
                w_nxt = (w_last_j && w_last_i && w_last_c) ? S_PR_DONE : S_PR_RD;
            end
            S_PR_DONE: begin
                w_done = 1'b1;
                w_nxt  = S_IDLE;
            end
            default: begin
                w_nxt = S_IDLE;
            end
        endcase
    end

    // Request capture, sweep indices, pending prune and row survivor tracking.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend  <= 1'b0;
            r_surv  <= 1'b0;
            r_apres <= 1'b0;
            r_awage <= {AGE_W{1'b0}};
            r_n1    <= {NW{1'b0}};
            r_n2    <= {NW{1'b0}};
            r_i     <= {NW{1'b0}};
            r_pi    <= {NW{1'b0}};
            r_pj    <= {NW{1'b0}};
            r_c     <= {CW{1'b0}};
            r_pc    <= {CW{1'b0}};
        end else begin
            if (r_state == S_IDLE) begin
                r_pend <= 1'b0;
            end else if (i_prune_start && w_upd_state) begin
                r_pend <= 1'b1;
            end else begin
                r_pend <= r_pend;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_nxt == S_SET_FWD) begin
                        r_n1 <= i_upd_node1;
                        r_n2 <= i_upd_node2;
                        r_c  <= i_upd_class;
                    end else if (w_nxt == S_PR_RD) begin
                        r_pc   <= CW'(1);
                        r_pi   <= NW'(1);
                        r_pj   <= NW'(1);
                        r_surv <= 1'b0;
                    end
                end
                S_SET_REV: r_i <= w_first[NW-1:0];
                S_AGE_WR1: begin
                    r_apres <= i_mem_rpres;
                    r_awage <= sat_inc(i_mem_rage);
                end
                S_AGE_WR2: r_i <= w_next[NW-1:0];
                S_PR_EVAL: begin
                    if (w_last_j) begin
                        r_surv <= 1'b0;
                        r_pj   <= NW'(1);
                        if (w_last_i) begin
                            r_pi <= NW'(1);
                            r_pc <= r_pc + CW'(1);
                        end else begin
                            r_pi <= r_pi + NW'(1);
                        end
                    end else begin
                        r_surv <= w_surv;
                        r_pj   <= r_pj + NW'(1);
                    end
                end
                default: begin
                    r_pend <= r_pend;
                end
            endcase
        end
    end

    assign o_upd_ready  = w_ready  & ~i_rst;
    assign o_upd_drop   = w_drop   & ~i_rst;
    assign o_prune_done = w_done   & ~i_rst;
    assign o_busy       = (r_state != S_IDLE) & ~i_rst;
    assign o_mem_en     = w_en     & ~i_rst;
    assign o_mem_we     = w_we     & ~i_rst;
    assign o_mem_wpres  = w_wpres  & ~i_rst;
    assign o_mem_class  = i_rst ? {CW{1'b0}} : w_class;
    assign o_mem_row    = i_rst ? {NW{1'b0}} : w_row;
    assign o_mem_col    = i_rst ? {NW{1'b0}} : w_col;
    assign o_mem_wage   = i_rst ? {AGE_W{1'b0}} : w_wage;
    assign o_inv_we     = w_inv_we & ~i_rst;
    assign o_inv_class  = i_rst ? {CW{1'b0}} : w_inv_class;
    assign o_inv_node   = i_rst ? {NW{1'b0}} : w_inv_node;

endmodule

// File: tb/tb_gam_connection_scheduler.sv
// Directed bench for gam_connection_scheduler with a behavioural single-port connection memory.
module tb_gam_connection_scheduler;

    logic       clk = 1'b0;
    logic       rst, upd_valid, prune_start;
    logic [2:0] n1, n2;
    logic [1:0] cls;
    logic       upd_ready, upd_drop, prune_done, busy;
    logic       mem_en, mem_we, mem_wpres, mem_rpres;
    logic [1:0] mem_class, inv_class;
    logic [2:0] mem_row, mem_col, inv_node;
    logic [7:0] mem_wage, mem_rage;
    logic       inv_we;

    logic       mp [4][8][8];
    logic [7:0] ma [4][8][8];
    logic [7:0] inv_mask [4];
    logic       pl_clr, pl_en, cnt_clr;
    logic [1:0] pl_c;
    logic [2:0] pl_r, pl_col;
    logic [7:0] pl_age;
    int         wr_cnt, en_cnt, inv_cnt, done_cnt;
    int         checks = 0, failures = 0;
    int         lat;

    always #5 clk = ~clk;

    gam_connection_scheduler dut (
        .i_clk(clk), .i_rst(rst), .i_upd_valid(upd_valid), .o_upd_ready(upd_ready),
        .i_upd_node1(n1), .i_upd_node2(n2), .i_upd_class(cls), .o_upd_drop(upd_drop),
        .i_prune_start(prune_start), .o_prune_done(prune_done), .o_busy(busy),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_class(mem_class),
        .o_mem_row(mem_row), .o_mem_col(mem_col), .o_mem_wpres(mem_wpres),
        .o_mem_wage(mem_wage), .i_mem_rpres(mem_rpres), .i_mem_rage(mem_rage),
        .o_inv_we(inv_we), .o_inv_class(inv_class), .o_inv_node(inv_node)
    );

    // Connection memory model plus activity counters.
    always @(posedge clk) begin
        if (pl_clr) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 8; r++)
                    for (int k = 0; k < 8; k++) begin
                        mp[c][r][k] <= 1'b0;
                        ma[c][r][k] <= 8'd0;
                    end
        end else if (pl_en) begin
            mp[pl_c][pl_r][pl_col] <= 1'b1;
            ma[pl_c][pl_r][pl_col] <= pl_age;
        end else if (mem_en && mem_we) begin
            mp[mem_class][mem_row][mem_col] <= mem_wpres;
            ma[mem_class][mem_row][mem_col] <= mem_wage;
        end
        if (mem_en && !mem_we) begin
            mem_rpres <= mp[mem_class][mem_row][mem_col];
            mem_rage  <= ma[mem_class][mem_row][mem_col];
        end
        if (cnt_clr) begin
            wr_cnt <= 0; en_cnt <= 0; inv_cnt <= 0; done_cnt <= 0;
            for (int c = 0; c < 4; c++) inv_mask[c] <= 8'd0;
        end else begin
            if (mem_en) en_cnt <= en_cnt + 1;
            if (mem_en && mem_we) wr_cnt <= wr_cnt + 1;
            if (prune_done) done_cnt <= done_cnt + 1;
            if (inv_we) begin
                inv_cnt <= inv_cnt + 1;
                inv_mask[inv_class] <= inv_mask[inv_class] | (8'd1 << inv_node);
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        pl_clr = 1'b1; cnt_clr = 1'b1;
        nxt();
        pl_clr = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic preload(input logic [1:0] c, input logic [2:0] r, input logic [2:0] k, input logic [7:0] a);
        pl_en = 1'b1; pl_c = c; pl_r = r; pl_col = k; pl_age = a;
        nxt();
        pl_en = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int exp_lat);
        while (!upd_ready && lat < 60) begin
            nxt();
            lat++;
        end
        chk(tag, lat, exp_lat);
    endtask

    initial begin
        rst = 1'b1; upd_valid = 1'b0; prune_start = 1'b0;
        n1 = 3'd0; n2 = 3'd0; cls = 2'd0;
        pl_clr = 1'b0; pl_en = 1'b0; cnt_clr = 1'b0;
        pl_c = 2'd0; pl_r = 3'd0; pl_col = 3'd0; pl_age = 8'd0;
        repeat (3) nxt();
        chk("rst_ready", upd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", upd_ready, 1);
        clear_all();

        // Update (1,2,1) on empty memory: only the two edge writes.
        upd_valid = 1'b1; n1 = 3'd1; n2 = 3'd2; cls = 2'd1;
        #1;
        chk("t1_accept_ready", upd_ready, 1);
        chk("t1_accept_drop", upd_drop, 0);
        nxt(); upd_valid = 1'b0; #1;
        chk("t1_fwd", {mem_en, mem_we, mem_wpres, mem_class, mem_row, mem_col, mem_wage},
            {3'b111, 2'd1, 3'd1, 3'd2, 8'd0});
        nxt();
        chk("t1_rev", {mem_en, mem_we, mem_wpres, mem_class, mem_row, mem_col, mem_wage},
            {3'b111, 2'd1, 3'd2, 3'd1, 8'd0});
        lat = 2;
        wait_ready("t1_latency", 18);
        chk("t1_writes", wr_cnt, 2);
        chk("t1_mem12", {mp[1][1][2], mp[1][2][1], ma[1][1][2], ma[1][2][1]}, {2'b11, 16'd0});

        // Age sweep with one normal and one saturating neighbour.
        preload(2'd1, 3'd1, 3'd3, 8'd4);
        preload(2'd1, 3'd3, 3'd1, 8'd4);
        preload(2'd1, 3'd1, 3'd5, 8'd255);
        preload(2'd1, 3'd5, 3'd1, 8'd255);
        cnt_clr = 1'b1; nxt(); cnt_clr = 1'b0;
        upd_valid = 1'b1; n1 = 3'd1; n2 = 3'd2; cls = 2'd1;
        nxt(); upd_valid = 1'b0;
        lat = 1;
        wait_ready("t2_latency", 18);
        chk("t2_age13", {ma[1][1][3], ma[1][3][1]}, {8'd5, 8'd5});
        chk("t2_age15", {ma[1][1][5], ma[1][5][1]}, {8'd255, 8'd255});
        chk("t2_writes", wr_cnt, 6);
        chk("t2_absent", {mp[1][1][4], mp[1][4][1], mp[1][1][6]}, 0);

        // Malformed requests are dropped in the accept cycle.
        cnt_clr = 1'b1; nxt(); cnt_clr = 1'b0;
        upd_valid = 1'b1; n1 = 3'd3; n2 = 3'd0; cls = 2'd1; #1;
        chk("t3_drop_n2zero", {upd_drop, upd_ready}, 2'b11);
        nxt(); upd_valid = 1'b0; #1;
        chk("t3_drop_pulse", {upd_drop, upd_ready, busy}, 3'b010);
        upd_valid = 1'b1; n1 = 3'd4; n2 = 3'd4; #1;
        chk("t3_drop_same", {upd_drop, upd_ready}, 2'b11);
        nxt(); upd_valid = 1'b1; n1 = 3'd1; n2 = 3'd2; cls = 2'd0; #1;
        chk("t3_drop_class0", {upd_drop, upd_ready}, 2'b11);
        nxt(); upd_valid = 1'b0; nxt();
        chk("t3_no_mem", en_cnt, 0);

        // Prune: one expired edge, one surviving edge in class 1.
        clear_all();
        preload(2'd1, 3'd2, 3'd4, 8'd10);
        preload(2'd1, 3'd4, 3'd2, 8'd10);
        preload(2'd1, 3'd1, 3'd2, 8'd3);
        preload(2'd1, 3'd2, 3'd1, 8'd3);
        cnt_clr = 1'b1; nxt(); cnt_clr = 1'b0;
        prune_start = 1'b1; upd_valid = 1'b1; n1 = 3'd5; n2 = 3'd6; cls = 2'd1; #1;
        chk("t4_prune_wins", {upd_ready, upd_drop}, 2'b00);
        nxt(); prune_start = 1'b0; upd_valid = 1'b0; #1;
        chk("t4_first_rd", {mem_en, mem_we, mem_class, mem_row, mem_col}, {2'b10, 2'd1, 3'd1, 3'd1});
        lat = 1;
        while (!prune_done && lat < 400) begin
            nxt();
            lat++;
        end
        chk("t4_prune_len", lat, 295);
        nxt();
        chk("t4_done_pulse", {prune_done, upd_ready, busy}, 3'b010);
        chk("t4_cleared", {mp[1][2][4], mp[1][4][2], ma[1][2][4]}, {2'b00, 8'd10});
        chk("t4_kept", {mp[1][1][2], mp[1][2][1]}, 2'b11);
        chk("t4_inv_c1", inv_mask[1], 8'hF8);
        chk("t4_inv_c23", {inv_mask[2], inv_mask[3], inv_mask[0]}, {8'hFE, 8'hFE, 8'h00});
        chk("t4_counts", {inv_cnt[7:0], done_cnt[7:0], wr_cnt[7:0]}, {8'd19, 8'd1, 8'd2});

        // prune_start mid-update is held until the update finishes.
        clear_all();
        upd_valid = 1'b1; n1 = 3'd3; n2 = 3'd4; cls = 2'd2;
        nxt(); upd_valid = 1'b0;
        repeat (4) nxt();
        prune_start = 1'b1;
        nxt(); prune_start = 1'b0;
        repeat (11) nxt();
        upd_valid = 1'b1; n1 = 3'd5; n2 = 3'd6; cls = 2'd1;
        nxt();
        chk("t5_pending_idle", {upd_ready, busy, mem_en}, 3'b000);
        nxt();
        chk("t5_pr_rd", {mem_en, mem_we, mem_class, mem_row, mem_col, busy}, {2'b10, 2'd1, 3'd1, 3'd1, 1'b1});
        chk("t5_upd_writes", wr_cnt, 2);
        lat = 0;
        while (!prune_done && lat < 400) begin
            nxt();
            lat++;
        end
        chk("t5_prune_len", lat, 294);
        chk("t5_no_accept", {upd_ready, mp[1][5][6]}, 2'b00);
        chk("t5_inv_cnt", inv_cnt, 19);
        nxt();
        chk("t5_accept_after", upd_ready, 1);
        nxt(); upd_valid = 1'b0; #1;
        chk("t5_set_fwd", {mem_en, mem_we, mem_class, mem_row, mem_col}, {2'b11, 2'd1, 3'd5, 3'd6});
        lat = 1;
        wait_ready("t5_upd2_latency", 18);

        // Reset in the middle of a prune abandons it.
        prune_start = 1'b1;
        nxt(); prune_start = 1'b0;
        repeat (99) nxt();
        chk("t6_busy_before", busy, 1);
        rst = 1'b1; cnt_clr = 1'b1; #1;
        chk("t6_rst_outputs", {mem_en, busy, upd_ready, inv_we, prune_done}, 0);
        nxt(); rst = 1'b0; cnt_clr = 1'b0; #1;
        chk("t6_after_rst", {upd_ready, busy, mem_en, prune_done}, 4'b1000);
        repeat (400) nxt();
        chk("t6_quiet", {done_cnt[7:0], inv_cnt[7:0], en_cnt[7:0]}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
